mem_arbiter: RTL and testbench

//  Shares the single external memory port between instruction fetch (port 0)
//  and the load/store unit (port 1). Forwards one request per handshake,

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/arb_tag_fifo.sv | 64 ++++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the two-port memory arbiter
package mem_arbiter_pkg;

  localparam int MTRANS_W = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic        we;
    logic [31:0] d;
  } mem_req_t;

  typedef enum logic {
    ARB_IF  = 1'b0,
    ARB_LSU = 1'b1
  } arb_owner_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    arb_owner_e owner;
    logic       kill;
  } arb_tag_t;

  function automatic arb_owner_e other_port(input arb_owner_e p);
    return (p == ARB_IF) ? ARB_LSU : ARB_IF;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// rtl/arb_tag_fifo.sv - circular owner-tag FIFO with per-owner kill marking
module arb_tag_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  arb_tag_t      push_tag,
  input  logic          pop,
  input  logic          kill_en,
  input  arb_owner_e    kill_owner,
  output arb_tag_t      head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  arb_tag_t      mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: kill marks matching entries, a push overwrites its slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{owner: ARB_IF, kill: 1'b0};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].owner == kill_owner) mem[i].kill <= 1'b1;
        if (do_push && wr_ptr == PW'(i)) mem[i] <= push_tag;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LSU arbiter onto one memory port; MEM_ARBITER_RR_EN selects round-robin
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_req_valid,
  output logic                         if_req_ready,
  input  mem_req_t                     if_req_data,
  output logic                         if_resp_valid,
  input  logic                         if_resp_ready,
  output logic [MTRANS_W-1:0]          if_resp_data,
  input  logic                         lsu_req_valid,
  output logic                         lsu_req_ready,
  input  mem_req_t                     lsu_req_data,
  output logic                         lsu_resp_valid,
  input  logic                         lsu_resp_ready,
  output logic [MTRANS_W-1:0]          lsu_resp_data,
  output logic                         down_req_valid,
  input  logic                         down_req_ready,
  output mem_req_t                     down_req_data,
  input  logic                         down_resp_valid,
  output logic                         down_resp_ready,
  input  logic [MTRANS_W-1:0]          down_resp_data,
  input  logic                         flush,
  output logic [$clog2(OUTSTANDING):0] inflight,
  output logic                         err
);

  localparam int CW = $clog2(OUTSTANDING) + 1;

  arb_state_e state;
  arb_owner_e lock_owner;
  arb_owner_e pick;
  logic       pick_valid;
  logic       v_if;
  logic       v_lsu;
  logic       lock_active;
  logic       req_hs;
  logic       resp_hs;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  arb_tag_t   fifo_head;

`ifdef MEM_ARBITER_RR_EN
  arb_owner_e rr_ptr;
`endif

  // A flush masks the port-0 request and releases a port-0 lock in the same cycle
  assign v_if        = if_req_valid && !flush;
  assign v_lsu       = lsu_req_valid;
  assign lock_active = (state == ARB_LOCKED) && !(flush && lock_owner == ARB_IF);

  // Grant selection: a held lock wins, otherwise the contention policy decides
  always_comb begin
    pick       = ARB_LSU;
    pick_valid = 1'b0;
    if (lock_active) begin
      pick       = lock_owner;
      pick_valid = (lock_owner == ARB_LSU) ? v_lsu : v_if;
    end else if (v_if && v_lsu) begin
`ifdef MEM_ARBITER_RR_EN
      pick       = rr_ptr;
`else
      pick       = ARB_LSU;
`endif
      pick_valid = 1'b1;
    end else if (v_if) begin
      pick       = ARB_IF;
      pick_valid = 1'b1;
    end else if (v_lsu) begin
      pick       = ARB_LSU;
      pick_valid = 1'b1;
    end
  end

  assign down_req_valid = rst && pick_valid && !fifo_full;
  assign down_req_data  = (pick == ARB_LSU) ? lsu_req_data : if_req_data;
  assign req_hs         = down_req_valid && down_req_ready;
  assign if_req_ready   = req_hs && (pick == ARB_IF);
  assign lsu_req_ready  = req_hs && (pick == ARB_LSU);

  // Response routing by head owner; killed entries and orphan responses are swallowed
  always_comb begin
    if_resp_valid   = 1'b0;
    lsu_resp_valid  = 1'b0;
    down_resp_ready = rst;
    if (!fifo_empty && !fifo_head.kill) begin
      if (fifo_head.owner == ARB_LSU) begin
        lsu_resp_valid  = rst && down_resp_valid;
        down_resp_ready = rst && lsu_resp_ready;
      end else begin
        if_resp_valid   = rst && down_resp_valid;
        down_resp_ready = rst && if_resp_ready;
      end
    end
  end

  assign if_resp_data  = down_resp_data;
  assign lsu_resp_data = down_resp_data;
  assign resp_hs       = down_resp_valid && down_resp_ready;
  assign fifo_pop      = resp_hs && !fifo_empty;

  // Arbitration FSM: lock onto a presented but unaccepted request until its handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      lock_owner <= ARB_IF;
    end else if (req_hs) begin
      state      <= ARB_IDLE;
    end else if (down_req_valid) begin
      state      <= ARB_LOCKED;
      lock_owner <= pick;
    end else if (state == ARB_LOCKED && flush && lock_owner == ARB_IF) begin
      state      <= ARB_IDLE;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Round-robin pointer favours the port that did not win the last grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rr_ptr <= ARB_LSU;
    else if (req_hs) rr_ptr <= other_port(pick);
  end
`endif

  // Sticky error for a response with nothing in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      err <= 1'b0;
    else if (resp_hs && fifo_empty) err <= 1'b1;
  end

  arb_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .CW    (CW)
  ) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (req_hs),
    .push_tag   ('{owner: pick, kill: 1'b0}),
    .pop        (fifo_pop),
    .kill_en    (flush),
    .kill_owner (ARB_IF),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (inflight)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int OUT = 2;

  logic        clk;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
  mem_req_t    if_req_data;
  logic [31:0] if_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_ready;
  mem_req_t    lsu_req_data;
  logic [31:0] lsu_resp_data;
  logic        down_req_valid, down_req_ready, down_resp_valid, down_resp_ready;
  mem_req_t    down_req_data;
  logic [31:0] down_resp_data;
  logic        flush;
  logic [1:0]  inflight;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Reference model state: in-flight owners in issue order, lock and policy memory
  int       tags[$];
  int       held;
  int       rr_pref;
  bit       if_act, lsu_act, rsp_act;
  mem_req_t if_pay, lsu_pay, pi, pl;
  logic [31:0] rsp_dat;
  bit       exp_l, prev_l, drained;

  mem_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_data(if_req_data),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_data(lsu_req_data),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data),
    .down_req_valid(down_req_valid), .down_req_ready(down_req_ready), .down_req_data(down_req_data),
    .down_resp_valid(down_resp_valid), .down_resp_ready(down_resp_ready), .down_resp_data(down_resp_data),
    .flush(flush), .inflight(inflight), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mem_req_t rand_pay();
    mem_req_t p;
    p.a  = $urandom;
    p.be = 4'($urandom);
    p.we = 1'($urandom);
    p.d  = $urandom;
    return p;
  endfunction

  task automatic idle_inputs();
    if_req_valid = 0; lsu_req_valid = 0; down_req_ready = 0; down_resp_valid = 0;
    if_resp_ready = 0; lsu_resp_ready = 0; flush = 0; down_resp_data = '0;
  endtask

  // One cycle of random traffic checked against the queue model
  task automatic rand_cycle(input bit drain);
    int pick;
    bit pv, full, exp_dv, push, pop, exp_drr;
    if (!drain && !if_act && $urandom_range(2) == 0) begin if_act = 1; if_pay = rand_pay(); end
    if (!drain && !lsu_act && $urandom_range(2) == 0) begin lsu_act = 1; lsu_pay = rand_pay(); end
    if (!rsp_act && tags.size() > 0 && (drain || $urandom_range(1) == 1)) begin
      rsp_act = 1;
      rsp_dat = $urandom;
    end
    if_req_valid    = if_act;  if_req_data  = if_pay;
    lsu_req_valid   = lsu_act; lsu_req_data = lsu_pay;
    down_req_ready  = drain ? 1'b1 : 1'($urandom_range(1));
    down_resp_valid = rsp_act; down_resp_data = rsp_dat;
    if_resp_ready   = drain ? 1'b1 : 1'($urandom_range(1));
    lsu_resp_ready  = drain ? 1'b1 : 1'($urandom_range(1));
    flush           = 0;
    #2;
    full = (tags.size() == OUT);
    if (held >= 0) begin
      pick = held; pv = 1;
    end else if (if_act && lsu_act) begin
`ifdef MEM_ARBITER_RR_EN
      pick = rr_pref;
`else
      pick = 1;
`endif
      pv = 1;
    end else begin
      pick = lsu_act ? 1 : 0;
      pv   = if_act || lsu_act;
    end
    exp_dv = pv && !full;
    push   = exp_dv && down_req_ready;
    chk1("r_down_valid", down_req_valid, exp_dv);
    chk1("r_if_ready", if_req_ready, push && pick == 0);
    chk1("r_lsu_ready", lsu_req_ready, push && pick == 1);
    if (exp_dv) begin
      chk32("r_down_a", down_req_data.a, pick ? lsu_pay.a : if_pay.a);
      chk32("r_down_d", down_req_data.d, pick ? lsu_pay.d : if_pay.d);
    end
    chk32("r_inflight", 32'(inflight), tags.size());
    chk1("r_err", err, 1'b0);
    pop = 0;
    if (rsp_act) begin
      exp_drr = (tags[0] == 1) ? lsu_resp_ready : if_resp_ready;
      chk1("r_down_resp_ready", down_resp_ready, exp_drr);
      chk1("r_if_resp_valid", if_resp_valid, tags[0] == 0);
      chk1("r_lsu_resp_valid", lsu_resp_valid, tags[0] == 1);
      chk32("r_resp_data", (tags[0] == 1) ? lsu_resp_data : if_resp_data, rsp_dat);
      pop = exp_drr;
    end else begin
      chk1("r_if_resp_idle", if_resp_valid, 1'b0);
      chk1("r_lsu_resp_idle", lsu_resp_valid, 1'b0);
    end
    if (pop) begin
      void'(tags.pop_front());
      rsp_act = 0;
    end
    if (push) begin
      tags.push_back(pick);
      held    = -1;
      rr_pref = 1 - pick;
      if (pick == 1) lsu_act = 0; else if_act = 0;
    end else if (exp_dv) begin
      held = pick;
    end
    tick();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    if_req_data = '0; lsu_req_data = '0;
    #2;
    // Outputs held inactive during reset even with live inputs
    if_req_valid = 1; down_req_ready = 1; down_resp_valid = 1;
    #2;
    chk1("rst_down_valid", down_req_valid, 1'b0);
    chk1("rst_if_ready", if_req_ready, 1'b0);
    chk1("rst_down_resp_ready", down_resp_ready, 1'b0);
    chk32("rst_inflight", 32'(inflight), 0);
    chk1("rst_err", err, 1'b0);
    idle_inputs();
    tick();
    rst = 1;

    // T1: single IF request and its response
    pi = rand_pay();
    if_req_valid = 1; if_req_data = pi; down_req_ready = 1;
    #2;
    chk1("t1_down_valid", down_req_valid, 1'b1);
    chk1("t1_if_ready", if_req_ready, 1'b1);
    chk1("t1_lsu_ready", lsu_req_ready, 1'b0);
    chk32("t1_down_a", down_req_data.a, pi.a);
    chk32("t1_down_d", down_req_data.d, pi.d);
    chk32("t1_inflight0", 32'(inflight), 0);
    tick();
    if_req_valid = 0; down_req_ready = 0;
    down_resp_valid = 1; down_resp_data = 32'hDEADBEEF; if_resp_ready = 1;
    #2;
    chk32("t1_inflight1", 32'(inflight), 1);
    chk1("t1_if_resp_valid", if_resp_valid, 1'b1);
    chk32("t1_if_resp_data", if_resp_data, 32'hDEADBEEF);
    chk1("t1_lsu_resp_valid", lsu_resp_valid, 1'b0);
    chk1("t1_down_resp_ready", down_resp_ready, 1'b1);
    tick();
    down_resp_valid = 0;
    #2;
    chk32("t1_inflight2", 32'(inflight), 0);

    // T2: both ports contend every cycle
    prev_l = 0;
    for (int k = 0; k < 5; k++) begin
      if_req_valid = (k < 4); lsu_req_valid = (k < 4); down_req_ready = 1;
      down_resp_valid = (k > 0); down_resp_data = 32'h100 + k;
      if_resp_ready = 1; lsu_resp_ready = 1;
      #2;
`ifdef MEM_ARBITER_RR_EN
      exp_l = (k % 2 == 0);
`else
      exp_l = 1;
`endif
      if (k < 4) begin
        chk1("t2_lsu_grant", lsu_req_ready, exp_l);
        chk1("t2_if_grant", if_req_ready, !exp_l);
      end
      if (k > 0) begin
        chk1("t2_resp_route", lsu_resp_valid, prev_l);
        chk32("t2_inflight", 32'(inflight), 1);
      end
      prev_l = exp_l;
      tick();
    end
    idle_inputs();
    #2;
    chk32("t2_drained", 32'(inflight), 0);

    // T3: LSU held by back-pressure while IF arrives
    pl = rand_pay(); pi = rand_pay();
    lsu_req_valid = 1; lsu_req_data = pl; down_req_ready = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin if_req_valid = 1; if_req_data = pi; end
      #2;
      chk1("t3_down_valid", down_req_valid, 1'b1);
      chk32("t3_payload_a", down_req_data.a, pl.a);
      chk32("t3_payload_d", down_req_data.d, pl.d);
      chk1("t3_if_wait", if_req_ready, 1'b0);
      tick();
    end
    down_req_ready = 1;
    #2;
    chk1("t3_lsu_hs", lsu_req_ready, 1'b1);
    chk1("t3_if_still_wait", if_req_ready, 1'b0);
    tick();
    lsu_req_valid = 0;
    #2;
    chk1("t3_if_hs", if_req_ready, 1'b1);
    chk32("t3_if_payload", down_req_data.a, pi.a);
    tick();

    // T4: full FIFO blocks new grants, pop without push when full
    if_req_valid = 0; pl = rand_pay();
    lsu_req_valid = 1; lsu_req_data = pl;
    #2;
    chk32("t4_full", 32'(inflight), 2);
    chk1("t4_blocked", down_req_valid, 1'b0);
    chk1("t4_no_ready", lsu_req_ready, 1'b0);
    tick();
    down_resp_valid = 1; down_resp_data = 32'hA0A0_0001; lsu_resp_ready = 1; if_resp_ready = 1;
    #2;
    chk1("t4_lsu_resp", lsu_resp_valid, 1'b1);
    chk32("t4_lsu_data", lsu_resp_data, 32'hA0A0_0001);
    chk1("t4_no_push_full", down_req_valid, 1'b0);
    tick();
    down_resp_data = 32'hA0A0_0002;
    #2;
    chk32("t4_after_pop", 32'(inflight), 1);
    chk1("t4_if_resp", if_resp_valid, 1'b1);
    chk1("t4_grant", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 0; down_resp_data = 32'hA0A0_0003;
    #2;
    chk32("t4_push_pop", 32'(inflight), 1);
    chk1("t4_lsu_resp2", lsu_resp_valid, 1'b1);
    tick();
    idle_inputs();
    #2;
    chk32("t4_drained", 32'(inflight), 0);

    // T5: flush kills an in-flight IF transaction
    down_req_ready = 1; if_req_valid = 1; if_req_data = rand_pay();
    #2;
    chk1("t5_if_hs", if_req_ready, 1'b1);
    tick();
    if_req_valid = 0; lsu_req_valid = 1; lsu_req_data = rand_pay();
    #2;
    chk1("t5_lsu_hs", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 0; flush = 1; if_req_valid = 1;
    #2;
    chk1("t5_flush_no_grant", if_req_ready, 1'b0);
    chk32("t5_inflight", 32'(inflight), 2);
    tick();
    flush = 0; if_req_valid = 0;
    down_resp_valid = 1; down_resp_data = 32'h5555_0001; if_resp_ready = 1; lsu_resp_ready = 1;
    #2;
    chk1("t5_killed_if_resp", if_resp_valid, 1'b0);
    chk1("t5_killed_lsu_resp", lsu_resp_valid, 1'b0);
    chk1("t5_killed_ready", down_resp_ready, 1'b1);
    tick();
    down_resp_data = 32'h5555_0002;
    #2;
    chk1("t5_lsu_resp", lsu_resp_valid, 1'b1);
    chk32("t5_lsu_data", lsu_resp_data, 32'h5555_0002);
    tick();
    idle_inputs();
    #2;
    chk32("t5_drained", 32'(inflight), 0);
    chk1("t5_err", err, 1'b0);

    // Flush while locked on IF releases the lock to LSU
    pi = rand_pay(); pl = rand_pay();
    if_req_valid = 1; if_req_data = pi; down_req_ready = 0;
    #2;
    chk32("lf_if_presented", down_req_data.a, pi.a);
    tick();
    flush = 1; lsu_req_valid = 1; lsu_req_data = pl;
    #2;
    chk1("lf_if_masked", if_req_ready, 1'b0);
    chk1("lf_down_valid", down_req_valid, 1'b1);
    chk32("lf_lsu_picked", down_req_data.a, pl.a);
    tick();
    flush = 0;
    #2;
    chk32("lf_lsu_locked", down_req_data.a, pl.a);
    tick();
    down_req_ready = 1;
    #2;
    chk1("lf_lsu_hs", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 0;
    #2;
    chk1("lf_if_hs", if_req_ready, 1'b1);
    tick();
    idle_inputs();
    down_resp_valid = 1; if_resp_ready = 1; lsu_resp_ready = 1;
    #2;
    chk1("lf_resp_lsu", lsu_resp_valid, 1'b1);
    tick();
    #2;
    chk1("lf_resp_if", if_resp_valid, 1'b1);
    tick();
    idle_inputs();

    // Random traffic against the model from a fresh reset
    rst = 0;
    tick();
    rst = 1;
    tags.delete(); held = -1; rr_pref = 1;
    if_act = 0; lsu_act = 0; rsp_act = 0; if_pay = '0; lsu_pay = '0; rsp_dat = '0;
    for (int n = 0; n < 300; n++) rand_cycle(1'b0);
    drained = 0;
    for (int n = 0; n < 30 && !drained; n++) begin
      rand_cycle(1'b1);
      drained = (tags.size() == 0) && !if_act && !lsu_act && !rsp_act;
    end
    chk1("r_drain_done", drained, 1'b1);
    idle_inputs();

    // T6: orphan response sets sticky err
    down_resp_valid = 1; down_resp_data = 32'h0BAD_0BAD;
    #2;
    chk1("t6_ready", down_resp_ready, 1'b1);
    chk1("t6_no_if_resp", if_resp_valid, 1'b0);
    chk1("t6_no_lsu_resp", lsu_resp_valid, 1'b0);
    tick();
    down_resp_valid = 0;
    #2;
    chk1("t6_err_set", err, 1'b1);
    tick();
    #2;
    chk1("t6_err_sticky", err, 1'b1);

    // Reset mid-transaction, then a late response
    if_req_valid = 1; down_req_ready = 1;
    tick();
    if_req_valid = 0;
    #2;
    chk32("rm_inflight", 32'(inflight), 1);
    rst = 0;
    #2;
    chk32("rm_cleared", 32'(inflight), 0);
    chk1("rm_err_cleared", err, 1'b0);
    tick();
    rst = 1;
    down_resp_valid = 1;
    #2;
    chk1("rm_late_ready", down_resp_ready, 1'b1);
    chk1("rm_late_no_resp", if_resp_valid, 1'b0);
    tick();
    down_resp_valid = 0;
    #2;
    chk1("rm_late_err", err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
